adc_sample_writer: RTL and testbench

- Capture stage directly upstream of the 32-bit single-port on-chip sample RAM (8192 words, 13-bit word address, 4-bit byteenable).
- Accepts a stream of 12-bit ADC samples, each with a 4-bit channel tag. Packs two tagged samples into one 32-bit word and writes it into RAM starting at a programmable base address.
- A Nios control path arms it with start/count/base and polls the busy/done status.
- The RAM write port has no waitrequest, so each write completes in one cycle.

---
 rtl/adc_sample_writer.sv | 221 ++++++++++++++++++++++
 tb/tb_adc_sample_writer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_writer.sv
// adc_sample_writer
// Packs pairs of tagged 12-bit ADC samples into 32-bit words and writes them
// into the single-port sample RAM, starting at a programmable base address.
// A control path arms a capture with start/count/base and polls busy/done.
//
// Handshake: a sample transfers on a rising clk edge when adc_valid and
// adc_ready are both high. adc_ready is high only in CAPTURE, and drops in the
// same cycle ctl_stop is seen, so a sample offered alongside a stop is not taken.
// adc_valid may be asserted at any time; the source holds data until accepted.
module adc_sample_writer #(
    parameter int ADDR_W   = 13,
    parameter int SAMPLE_W = 12,
    parameter int CNT_W    = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ctl_start,
    input  logic                ctl_stop,
    input  logic [ADDR_W-1:0]   ctl_base,
    input  logic [CNT_W-1:0]    ctl_count,
    input  logic                adc_valid,
    input  logic [3:0]          adc_channel,
    input  logic [SAMPLE_W-1:0] adc_data,
    output logic                adc_ready,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [3:0]          mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [31:0]         mem_writedata,
    output logic                mem_clken,
    output logic                sts_busy,
    output logic                sts_done,
    output logic                sts_aborted,
    output logic [ADDR_W:0]     sts_words
);

    // One tagged sample occupies a halfword: {channel, sample}.
    localparam int HALF_W = 4 + SAMPLE_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [ADDR_W-1:0]   base_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    acc_cnt_q;
    logic [ADDR_W:0]     words_q;
    logic [HALF_W-1:0]   hold_q;
    logic                hold_valid_q;
    logic                done_q;
    logic                aborted_q;

    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;

    // Control strobes from the FSM into the datapath.
    logic                start_acc;
    logic                do_hold;
    logic                do_pair;
    logic                do_flush;
    logic                set_done;
    logic                set_abort;

    logic [HALF_W-1:0]   cur_half;
    logic                last_sample;
    logic [ADDR_W-1:0]   next_addr;

    assign cur_half    = {adc_channel, adc_data};
    assign last_sample = (acc_cnt_q + CNT_W'(1)) == count_q;
    assign next_addr   = base_q + words_q[ADDR_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, acceptance and datapath strobes.
    always_comb begin
        state_d   = state_q;
        adc_ready = 1'b0;
        start_acc = 1'b0;
        do_hold   = 1'b0;
        do_pair   = 1'b0;
        do_flush  = 1'b0;
        set_done  = 1'b0;
        set_abort = 1'b0;
        case (state_q)
            IDLE: begin
                // A start outranks a simultaneous stop here: stop means nothing while idle.
                if (ctl_start) begin
                    start_acc = 1'b1;
                    if (ctl_count == '0) begin
                        set_done = 1'b1;
                    end else begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (ctl_stop) begin
                    set_abort = 1'b1;
                    if (hold_valid_q) begin
                        do_flush = 1'b1;
                        state_d  = FLUSH;
                    end else begin
                        set_done = 1'b1;
                        state_d  = IDLE;
                    end
                end else begin
                    adc_ready = ~reset;
                    if (adc_valid && !reset) begin
                        if (!hold_valid_q) begin
                            do_hold = 1'b1;
                            if (last_sample) begin
                                do_flush = 1'b1;
                                state_d  = FLUSH;
                            end
                        end else begin
                            do_pair = 1'b1;
                            if (last_sample) begin
                                set_done = 1'b1;
                                state_d  = IDLE;
                            end
                        end
                    end
                end
            end
            FLUSH: begin
                // The flush word is on the bus during this cycle; finish next.
                set_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture bookkeeping, hold register, status and the registered RAM write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q       <= '0;
            count_q      <= '0;
            acc_cnt_q    <= '0;
            words_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
        end else begin
            write_q <= 1'b0;
            if (start_acc) begin
                base_q       <= ctl_base;
                count_q      <= ctl_count;
                acc_cnt_q    <= '0;
                words_q      <= '0;
                hold_valid_q <= 1'b0;
                done_q       <= 1'b0;
                aborted_q    <= 1'b0;
            end
            if (set_done) begin
                done_q <= 1'b1;
            end
            if (set_abort) begin
                aborted_q <= 1'b1;
            end
            if (do_hold) begin
                hold_q       <= cur_half;
                hold_valid_q <= 1'b1;
                acc_cnt_q    <= acc_cnt_q + CNT_W'(1);
            end
            if (do_pair) begin
                hold_valid_q <= 1'b0;
                acc_cnt_q    <= acc_cnt_q + CNT_W'(1);
                write_q      <= 1'b1;
                addr_q       <= next_addr;
                be_q         <= 4'hF;
                wdata_q      <= {cur_half, hold_q};
                words_q      <= words_q + (ADDR_W + 1)'(1);
            end
            // A flush either carries the sample just taken (odd count) or the held one (stop).
            if (do_flush) begin
                hold_valid_q <= 1'b0;
                write_q      <= 1'b1;
                addr_q       <= next_addr;
                be_q         <= 4'b0011;
                wdata_q      <= {{(32 - HALF_W){1'b0}}, (do_hold ? cur_half : hold_q)};
                words_q      <= words_q + (ADDR_W + 1)'(1);
            end
        end
    end

    // A write pending when reset arrives is suppressed in that same cycle.
    assign mem_write      = write_q & ~reset;
    assign mem_chipselect = mem_write;
    assign mem_address    = addr_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = wdata_q;
    assign mem_clken      = 1'b1;

    assign sts_busy    = (state_q != IDLE);
    assign sts_done    = done_q;
    assign sts_aborted = aborted_q;
    assign sts_words   = words_q;

endmodule

// File: tb/tb_adc_sample_writer.sv
// Directed testbench for adc_sample_writer.
module tb_adc_sample_writer;

    localparam int ADDR_W   = 13;
    localparam int SAMPLE_W = 12;
    localparam int CNT_W    = 15;
    localparam int WR_W     = ADDR_W + 4 + 32;

    logic                clk;
    logic                reset;
    logic                ctl_start;
    logic                ctl_stop;
    logic [ADDR_W-1:0]   ctl_base;
    logic [CNT_W-1:0]    ctl_count;
    logic                adc_valid;
    logic [3:0]          adc_channel;
    logic [SAMPLE_W-1:0] adc_data;
    logic                adc_ready;
    logic [ADDR_W-1:0]   mem_address;
    logic [3:0]          mem_byteenable;
    logic                mem_chipselect;
    logic                mem_write;
    logic [31:0]         mem_writedata;
    logic                mem_clken;
    logic                sts_busy;
    logic                sts_done;
    logic                sts_aborted;
    logic [ADDR_W:0]     sts_words;

    int errors = 0;
    int checks = 0;

    // Writes seen on the RAM port and the writes the bench expects, {addr, be, data}.
    logic [WR_W-1:0] obs_q[$];
    logic [WR_W-1:0] exp_q[$];

    adc_sample_writer #(
        .ADDR_W  (ADDR_W),
        .SAMPLE_W(SAMPLE_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ctl_start     (ctl_start),
        .ctl_stop      (ctl_stop),
        .ctl_base      (ctl_base),
        .ctl_count     (ctl_count),
        .adc_valid     (adc_valid),
        .adc_channel   (adc_channel),
        .adc_data      (adc_data),
        .adc_ready     (adc_ready),
        .mem_address   (mem_address),
        .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect),
        .mem_write     (mem_write),
        .mem_writedata (mem_writedata),
        .mem_clken     (mem_clken),
        .sts_busy      (sts_busy),
        .sts_done      (sts_done),
        .sts_aborted   (sts_aborted),
        .sts_words     (sts_words)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (mem_write) begin
            obs_q.push_back({mem_address, mem_byteenable, mem_writedata});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_sample(input logic [3:0] ch, input logic [SAMPLE_W-1:0] d);
        adc_valid   = 1'b1;
        adc_channel = ch;
        adc_data    = d;
    endtask

    task automatic arm(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
        ctl_start = 1'b1;
        ctl_base  = base;
        ctl_count = cnt;
        tick();
        ctl_start = 1'b0;
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [3:0] be, input logic [31:0] d);
        exp_q.push_back({a, be, d});
    endtask

    initial begin
        // Clock/reset
        reset       = 1'b1;
        ctl_start   = 1'b0;
        ctl_stop    = 1'b0;
        ctl_base    = '0;
        ctl_count   = '0;
        adc_valid   = 1'b0;
        adc_channel = '0;
        adc_data    = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        chk("rst_ready",  64'(adc_ready), 64'd0);
        chk("rst_write",  64'(mem_write), 64'd0);
        chk("rst_cs",     64'(mem_chipselect), 64'd0);
        chk("rst_addr",   64'(mem_address), 64'd0);
        chk("rst_be",     64'(mem_byteenable), 64'd0);
        chk("rst_data",   64'(mem_writedata), 64'd0);
        chk("rst_clken",  64'(mem_clken), 64'd1);
        chk("rst_status", 64'({sts_busy, sts_done, sts_aborted}), 64'd0);
        chk("rst_words",  64'(sts_words), 64'd0);

        // Base 0, count 4: two full words, each one cycle after its second sample.
        arm(13'd0, 15'd4);
        chk("t1_busy", 64'(sts_busy), 64'd1);
        chk("t1_ready", 64'(adc_ready), 64'd1);
        drive_sample(4'd1, 12'h123); tick();
        chk("t1_nowrite0", 64'(mem_write), 64'd0);
        drive_sample(4'd2, 12'h456); tick();
        chk("t1_w0", 64'({mem_write, mem_chipselect, mem_address, mem_byteenable, mem_writedata}),
            64'({1'b1, 1'b1, 13'd0, 4'hF, 32'h2456_1123}));
        chk("t1_words1", 64'(sts_words), 64'd1);
        drive_sample(4'd3, 12'h789); tick();
        chk("t1_gap", 64'({mem_write, mem_chipselect, mem_address, mem_writedata}),
            64'({1'b0, 1'b0, 13'd0, 32'h2456_1123}));
        drive_sample(4'd4, 12'hABC); tick();
        adc_valid = 1'b0;
        chk("t1_w1", 64'({mem_write, mem_address, mem_byteenable, mem_writedata}),
            64'({1'b1, 13'd1, 4'hF, 32'h4ABC_3789}));
        chk("t1_end_status", 64'({sts_busy, sts_done, sts_aborted}), 64'b010);
        chk("t1_words", 64'(sts_words), 64'd2);
        push_exp(13'd0, 4'hF, 32'h2456_1123);
        push_exp(13'd1, 4'hF, 32'h4ABC_3789);
        tick();
        chk("t1_idle_ready", 64'({adc_ready, mem_write}), 64'd0);

        // Base 0x10, count 3: one full word, then a flush halfword.
        arm(13'h10, 15'd3);
        chk("t2_done_cleared", 64'({sts_busy, sts_done}), 64'b10);
        drive_sample(4'd1, 12'h123); tick();
        drive_sample(4'd2, 12'h456); tick();
        chk("t2_w0", 64'({mem_write, mem_address, mem_byteenable, mem_writedata}),
            64'({1'b1, 13'h10, 4'hF, 32'h2456_1123}));
        drive_sample(4'd3, 12'h789); tick();
        adc_valid = 1'b0;
        chk("t2_flush", 64'({mem_write, mem_address, mem_byteenable, mem_writedata}),
            64'({1'b1, 13'h11, 4'b0011, 32'h0000_3789}));
        chk("t2_flush_ready", 64'(adc_ready), 64'd0);
        tick();
        chk("t2_end_status", 64'({sts_busy, sts_done, sts_aborted}), 64'b010);
        chk("t2_words", 64'(sts_words), 64'd2);
        push_exp(13'h10, 4'hF, 32'h2456_1123);
        push_exp(13'h11, 4'b0011, 32'h0000_3789);

        // Base 8191, count 4: second word wraps to address 0.
        arm(13'd8191, 15'd4);
        drive_sample(4'd1, 12'h123); tick();
        drive_sample(4'd2, 12'h456); tick();
        chk("t3_w0_addr", 64'({mem_write, mem_address}), 64'({1'b1, 13'd8191}));
        drive_sample(4'd3, 12'h789); tick();
        drive_sample(4'd4, 12'hABC); tick();
        adc_valid = 1'b0;
        chk("t3_w1_addr", 64'({mem_write, mem_address}), 64'({1'b1, 13'd0}));
        chk("t3_done", 64'({sts_done, sts_words}), 64'({1'b1, 14'd2}));
        push_exp(13'd8191, 4'hF, 32'h2456_1123);
        push_exp(13'd0, 4'hF, 32'h4ABC_3789);
        tick();

        // Base 0x20, count 6, stop after 3 samples; a sample offered with stop is dropped.
        arm(13'h20, 15'd6);
        drive_sample(4'd1, 12'h111); tick();
        drive_sample(4'd2, 12'h222); tick();
        chk("t4_w0", 64'({mem_write, mem_address, mem_writedata}),
            64'({1'b1, 13'h20, 32'h2222_1111}));
        drive_sample(4'd3, 12'h333); tick();
        drive_sample(4'd5, 12'hFFF);
        ctl_stop = 1'b1;
        #1;
        chk("t4_ready_drop", 64'(adc_ready), 64'd0);
        tick();
        ctl_stop  = 1'b0;
        adc_valid = 1'b0;
        chk("t4_flush", 64'({mem_write, mem_address, mem_byteenable, mem_writedata}),
            64'({1'b1, 13'h21, 4'b0011, 32'h0000_3333}));
        tick();
        chk("t4_end_status", 64'({sts_busy, sts_done, sts_aborted}), 64'b011);
        chk("t4_words", 64'(sts_words), 64'd2);
        push_exp(13'h20, 4'hF, 32'h2222_1111);
        push_exp(13'h21, 4'b0011, 32'h0000_3333);
        tick();

        // Reset in the cycle after a pair completes: that write never appears.
        arm(13'h40, 15'd8);
        drive_sample(4'd6, 12'h0AA); tick();
        drive_sample(4'd7, 12'h0BB); tick();
        adc_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk("t5_write_suppressed", 64'({mem_write, mem_chipselect}), 64'd0);
        tick();
        reset = 1'b0;
        chk("t5_rst_port", 64'({mem_write, mem_chipselect, mem_address, mem_byteenable, mem_writedata}), 64'd0);
        chk("t5_rst_status", 64'({adc_ready, sts_busy, sts_done, sts_aborted, sts_words}), 64'd0);
        chk("t5_rst_clken", 64'(mem_clken), 64'd1);
        tick();
        chk("t5_after", 64'({mem_write, sts_busy}), 64'd0);

        // Count 0: done next cycle, no write, stays idle.
        arm(13'h55, 15'd0);
        chk("t6_zero", 64'({sts_busy, sts_done, mem_write, sts_words}), 64'({1'b0, 1'b1, 1'b0, 14'd0}));

        // A second start while busy is ignored: base 0x60, count 2 stand.
        arm(13'h60, 15'd2);
        drive_sample(4'd7, 12'h001);
        ctl_start = 1'b1;
        ctl_base  = 13'h70;
        ctl_count = 15'd6;
        tick();
        ctl_start = 1'b0;
        drive_sample(4'd8, 12'h002); tick();
        adc_valid = 1'b0;
        chk("t6_busy_start", 64'({mem_write, mem_address, mem_writedata}),
            64'({1'b1, 13'h60, 32'h8002_7001}));
        chk("t6_done", 64'({sts_busy, sts_done, sts_words}), 64'({1'b0, 1'b1, 14'd1}));
        push_exp(13'h60, 4'hF, 32'h8002_7001);
        tick();
        tick();

        // Scoreboard: every write on the port, in order.
        chk("sb_count", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                chk($sformatf("sb_write%0d", i), 64'(obs_q[i]), 64'(exp_q[i]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
